key_conditioner: RTL and testbench

//  Conditions the NUM_KEYS raw push-buttons (inum_1, inum_2, confirm, game reset) before the game core.
//  Per key: 2-flop synchroniser, debounce filter, clean level, 1-cycle press/release pulses.

---
 rtl/key_conditioner_pkg.sv | 36 +++
 rtl/key_conditioner_if.sv | 37 +++
 rtl/key_conditioner_channel.sv | 168 ++++++++++++++++
 rtl/key_conditioner.sv | 59 +++++
 tb/tb_key_conditioner.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/key_conditioner_pkg.sv
// Shared definitions for the key conditioner: per-key FSM state encoding,
// 12 MHz-derived default timing constants and counter sizing helpers.
package key_conditioner_pkg;

    // Per-key debounce / long-press FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,  // released, waiting for a raw press
        ST_ARM_P   = 3'd1,  // raw pressed, qualifying the press
        ST_PRESSED = 3'd2,  // accepted press, counting towards long-press
        ST_HELD    = 3'd3,  // long-press active, emitting repeat pulses
        ST_ARM_R   = 3'd4   // raw released, qualifying the release
    } key_state_e;

    localparam int STATE_W = 3;

    // Default timing derived from the 12 MHz system clock.
    localparam int CLK_HZ                = 12_000_000;
    localparam int DEF_DEBOUNCE_CYCLES   = CLK_HZ / 50;   // 20 ms
    localparam int DEF_HOLD_CYCLES       = CLK_HZ / 2;    // 0.5 s
    localparam int DEF_REPEAT_CYCLES     = CLK_HZ / 10;   // 100 ms

    // Largest of three cycle parameters.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One counter width shared by all three counters of a channel.
    function automatic int cnt_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c));
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bundle between the raw button pins and the game core. The master side
// drives the raw buttons and observes the conditioned outputs; the slave side
// is the conditioner itself. key_state exposes every channel's FSM state.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    import key_conditioner_pkg::*;

    logic [NUM_KEYS-1:0]              key_raw;
    logic [NUM_KEYS-1:0]              key_level;
    logic [NUM_KEYS-1:0]              key_press;
    logic [NUM_KEYS-1:0]              key_release;
    logic [NUM_KEYS-1:0]              key_hold;
    logic [NUM_KEYS-1:0]              key_repeat;
    logic [NUM_KEYS-1:0][STATE_W-1:0] key_state;

    modport master (
        output key_raw,
        input  key_level,
        input  key_press,
        input  key_release,
        input  key_hold,
        input  key_repeat,
        input  key_state
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_press,
        output key_release,
        output key_hold,
        output key_repeat,
        output key_state
    );

endinterface

// File: rtl/key_conditioner_channel.sv
// One key channel: 2-flop synchroniser, debounce FSM, long-press and
// auto-repeat counters. All outputs are registered.
module key_channel
    import key_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_raw_i,
    output logic               key_level_o,
    output logic               key_press_o,
    output logic               key_release_o,
    output logic               key_hold_o,
    output logic               key_repeat_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [CNT_W-1:0] D_LIM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] H_LIM = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] R_LIM = CNT_W'(REPEAT_CYCLES - 1);

    // Counters stop at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic       s1_q, s1_d;
    logic       s2_q, s2_d;
    key_state_e state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic level_q,   level_d;
    logic press_q,   press_d;
    logic release_q, release_d;
    logic hold_q,    hold_d;
    logic repeat_q,  repeat_d;

    // State register: reset returns to released level, IDLE, zero counters and quiet outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            state_q   <= ST_IDLE;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            rcnt_q    <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            rcnt_q    <= rcnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            repeat_q  <= repeat_d;
        end
    end

    // Synchroniser, next-state and output logic; the FSM only ever looks at s2.
    always_comb begin
        s1_d      = key_raw_i ^ ACTIVE_LOW;
        s2_d      = s1_q;
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        hcnt_d    = hcnt_q;
        rcnt_d    = rcnt_q;
        level_d   = level_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s2_q) begin
                    state_d = ST_ARM_P;
                    dcnt_d  = '0;
                end
            end

            // The incremented count is tested so the press lands exactly
            // DEBOUNCE_CYCLES+2 edges after the raw change.
            ST_ARM_P: begin
                if (!s2_q) begin
                    state_d = ST_IDLE;
                end else begin
                    dcnt_d = sat_inc(dcnt_q);
                    if (dcnt_d == D_LIM) begin
                        state_d = ST_PRESSED;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        hcnt_d  = '0;
                    end
                end
            end

            // Long-press fires HOLD_CYCLES edges after the press edge.
            ST_PRESSED: begin
                if (!s2_q) begin
                    state_d = ST_ARM_R;
                    dcnt_d  = '0;
                end else if (hcnt_q == H_LIM) begin
                    state_d = ST_HELD;
                    hold_d  = 1'b1;
                    rcnt_d  = '0;
                end else begin
                    hcnt_d = sat_inc(hcnt_q);
                end
            end

            // Repeat every REPEAT_CYCLES edges; the entry edge itself is quiet.
            ST_HELD: begin
                if (!s2_q) begin
                    state_d = ST_ARM_R;
                    dcnt_d  = '0;
                end else if (rcnt_q == R_LIM) begin
                    repeat_d = 1'b1;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = sat_inc(rcnt_q);
                end
            end

            // Level stays high while a release is being qualified; a bounce
            // back resumes the previous state with hold/repeat counts intact.
            ST_ARM_R: begin
                if (s2_q) begin
                    state_d = hold_q ? ST_HELD : ST_PRESSED;
                end else begin
                    dcnt_d = sat_inc(dcnt_q);
                    if (dcnt_d == D_LIM) begin
                        state_d   = ST_IDLE;
                        level_d   = 1'b0;
                        hold_d    = 1'b0;
                        release_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign key_level_o   = level_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;
    assign key_hold_o    = hold_q;
    assign key_repeat_o  = repeat_q;
    assign state_o       = state_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: NUM_KEYS independent debounced channels with
// press/release pulses, long-press flag and auto-repeat, all on clk_12MHz.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int ACTIVE_LOW      = 0
) (
    input  logic              clk_12MHz,
    input  logic              reset,
    key_conditioner_if.slave  kif
);

    // Timing parameters below 2 leave no room for a qualify window.
    if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
        $error("key_conditioner: DEBOUNCE/HOLD/REPEAT_CYCLES must all be >= 2");
    end

    if (NUM_KEYS < 1) begin : g_bad_keys
        $error("key_conditioner: NUM_KEYS must be >= 1");
    end

    logic [NUM_KEYS-1:0]              level_w;
    logic [NUM_KEYS-1:0]              press_w;
    logic [NUM_KEYS-1:0]              release_w;
    logic [NUM_KEYS-1:0]              hold_w;
    logic [NUM_KEYS-1:0]              repeat_w;
    logic [NUM_KEYS-1:0][STATE_W-1:0] state_w;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW != 0)
        ) u_channel (
            .clk           (clk_12MHz),
            .reset         (reset),
            .key_raw_i     (kif.key_raw[i]),
            .key_level_o   (level_w[i]),
            .key_press_o   (press_w[i]),
            .key_release_o (release_w[i]),
            .key_hold_o    (hold_w[i]),
            .key_repeat_o  (repeat_w[i]),
            .state_o       (state_w[i])
        );
    end

    assign kif.key_level   = level_w;
    assign kif.key_press   = press_w;
    assign kif.key_release = release_w;
    assign kif.key_hold    = hold_w;
    assign kif.key_repeat  = repeat_w;
    assign kif.key_state   = state_w;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with short timing (debounce 4, hold 20, repeat 5).
// Expected output events are pushed with their cycle number when stimulus is
// driven; a negedge monitor pops and compares them, and checks quiet cycles.
module tb_key_conditioner;
    import key_conditioner_pkg::*;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int HC = 20;
    localparam int RC = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    key_conditioner_if #(.NUM_KEYS(NK)) kif ();
    key_conditioner_if #(.NUM_KEYS(NK)) kif_al ();

    key_conditioner #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC),
        .REPEAT_CYCLES(RC), .ACTIVE_LOW(0)
    ) dut (
        .clk_12MHz (clk),
        .reset     (reset),
        .kif       (kif)
    );

    key_conditioner #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC),
        .REPEAT_CYCLES(RC), .ACTIVE_LOW(1)
    ) dut_al (
        .clk_12MHz (clk),
        .reset     (reset),
        .kif       (kif_al)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // Entry: {cycle[15:0], press, release, repeat, level, hold}
    logic [35:0] exp_q[$];
    logic [NK-1:0] exp_level = '0;
    logic [NK-1:0] exp_hold  = '0;
    logic [NK-1:0] cur_level = '0;
    logic [NK-1:0] cur_hold  = '0;
    bit mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input int c, input logic [NK-1:0] p, input logic [NK-1:0] r,
                           input logic [NK-1:0] rp);
        logic [15:0] c16;
        c16 = c[15:0];
        exp_q.push_back({c16, p, r, rp, exp_level, exp_hold});
    endtask

    // Events of one clean press at cycle c and release at cycle r. 'frozen' is the
    // number of press-phase edges lost to release glitches.
    task automatic push_key(input int k, input int c, input int r, input int frozen);
        logic [NK-1:0] m;
        int press_e, hold_e, last_hi;
        m       = 4'b0001 << k;
        press_e = c + DB + 2;
        hold_e  = press_e + HC + frozen;
        last_hi = r + 2;
        exp_level[k] = 1'b1;
        push_ev(press_e, m, '0, '0);
        if (hold_e <= last_hi) begin
            exp_hold[k] = 1'b1;
            push_ev(hold_e, '0, '0, '0);
            for (int e = hold_e + RC; e <= last_hi; e += RC)
                push_ev(e, '0, '0, m);
        end
        exp_level[k] = 1'b0;
        exp_hold[k]  = 1'b0;
        push_ev(r + DB + 2, '0, m, '0);
    endtask

    // Every monitored cycle is either a scheduled event or must be quiet.
    always @(negedge clk) begin : mon
        logic [35:0] obs;
        logic [35:0] exp;
        if (mon_en) begin
            obs = {cyc[15:0], kif.key_press, kif.key_release, kif.key_repeat,
                   kif.key_level, kif.key_hold};
            if (exp_q.size() > 0 && int'(exp_q[0][35:20]) <= cyc) begin
                exp = exp_q.pop_front();
                cur_level = exp[7:4];
                cur_hold  = exp[3:0];
                n_checks++;
                assert (obs === exp) else begin
                    n_fail++;
                    $error("FAIL event: observed %h expected %h", obs, exp);
                end
            end else begin
                n_checks++;
                assert (obs[19:0] === {12'b0, cur_level, cur_hold}) else begin
                    n_fail++;
                    $error("FAIL quiet @%0d: observed %h expected %h", cyc, obs[19:0],
                           {12'b0, cur_level, cur_hold});
                end
            end
        end
    end

    // Active-low instance must stay silent until it is deliberately pressed.
    bit al_armed = 1'b0;
    logic al_spurious = 1'b0;
    always @(negedge clk) begin
        if (mon_en && !al_armed)
            al_spurious <= al_spurious | (|{kif_al.key_press, kif_al.key_release,
                                            kif_al.key_repeat, kif_al.key_level, kif_al.key_hold});
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_key(input int k, input int hi_len, input int frozen);
        int c;
        c = cyc;
        kif.key_raw[k] = 1'b1;
        push_key(k, c, c + hi_len, frozen);
        wait_cyc(hi_len);
        kif.key_raw[k] = 1'b0;
        wait_cyc(DB + 6);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        int c;
        reset = 1'b1;
        kif.key_raw    = '0;
        kif_al.key_raw = '1;
        wait_cyc(3);

        check("reset_level",   {60'b0, kif.key_level},   64'h0);
        check("reset_press",   {60'b0, kif.key_press},   64'h0);
        check("reset_release", {60'b0, kif.key_release}, 64'h0);
        check("reset_hold",    {60'b0, kif.key_hold},    64'h0);
        check("reset_repeat",  {60'b0, kif.key_repeat},  64'h0);
        check("reset_state",   {52'b0, kif.key_state},   64'h0);
        check("reset_al_out",  {44'b0, kif_al.key_press, kif_al.key_level, kif_al.key_hold,
                                kif_al.key_release, kif_al.key_repeat}, 64'h0);

        reset  = 1'b0;
        mon_en = 1'b1;
        wait_cyc(3);

        // Clean press/release on key 0.
        do_key(0, 10, 0);

        // Key 1 bounces, then settles high; one press six edges after the last rise.
        c = cyc;
        kif.key_raw[1] = 1'b1; wait_cyc(2);
        kif.key_raw[1] = 1'b0; wait_cyc(2);
        kif.key_raw[1] = 1'b1; wait_cyc(2);
        kif.key_raw[1] = 1'b0; wait_cyc(2);
        kif.key_raw[1] = 1'b1;
        push_key(1, c + 8, c + 20, 0);
        wait_cyc(12);
        kif.key_raw[1] = 1'b0;
        wait_cyc(10);

        // Key 2 held 40 cycles after the press: hold flag then four repeats.
        do_key(2, DB + 2 + 40, 0);

        // Key 0 with a 2-cycle release glitch while pressed.
        c = cyc;
        kif.key_raw[0] = 1'b1;
        push_key(0, c, c + 36, 3);
        wait_cyc(10);
        kif.key_raw[0] = 1'b0; wait_cyc(2);
        kif.key_raw[0] = 1'b1; wait_cyc(24);
        kif.key_raw[0] = 1'b0;
        wait_cyc(10);

        // Keys 0 and 3 together.
        c = cyc;
        kif.key_raw = 4'b1001;
        exp_level = 4'b1001;
        push_ev(c + DB + 2, 4'b1001, '0, '0);
        exp_level = 4'b0000;
        push_ev(c + DB + 12, '0, 4'b1001, '0);
        wait_cyc(10);
        kif.key_raw = 4'b0000;
        wait_cyc(12);

        // Reset while key 1 is HELD; the still-pressed key re-qualifies afterwards.
        c = cyc;
        kif.key_raw[1] = 1'b1;
        exp_level[1] = 1'b1;
        push_ev(c + DB + 2, 4'b0010, '0, '0);
        exp_hold[1] = 1'b1;
        push_ev(c + DB + 2 + HC, '0, '0, '0);
        exp_level = '0;
        exp_hold  = '0;
        push_ev(c + 29, '0, '0, '0);
        push_key(1, c + 31, c + 40, 0);
        wait_cyc(28);
        reset = 1'b1;
        wait_cyc(1);
        check("rst_mid_level",   {60'b0, kif.key_level},   64'h0);
        check("rst_mid_hold",    {60'b0, kif.key_hold},    64'h0);
        check("rst_mid_release", {60'b0, kif.key_release}, 64'h0);
        check("rst_mid_state",   {52'b0, kif.key_state},   64'h0);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(9);
        kif.key_raw[1] = 1'b0;
        wait_cyc(12);

        // Active-low instance: idle-high input gives nothing; a 0 presses key 0.
        check("al_idle_silent", {63'b0, al_spurious}, 64'h0);
        al_armed = 1'b1;
        kif_al.key_raw[0] = 1'b0;
        wait_cyc(DB + 1);
        check("al_press_early", {56'b0, kif_al.key_press, kif_al.key_level}, 64'h0);
        wait_cyc(1);
        check("al_press",       {56'b0, kif_al.key_press, kif_al.key_level}, 64'h11);
        wait_cyc(1);
        check("al_press_width", {56'b0, kif_al.key_press, kif_al.key_level}, 64'h01);
        kif_al.key_raw[0] = 1'b1;
        wait_cyc(DB + 2);
        check("al_release",     {56'b0, kif_al.key_release, kif_al.key_level}, 64'h10);

        // Drain remaining expectations within a bounded window.
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
